ahb_dma_master: RTL

- Single-channel AHB-Lite bus master that copies a block of 32-bit words from a source address to a destination address.
- Sits directly upstream of the on-chip AHB-Lite memory slaves and drives their HADDR/HTRANS/HWRITE/HSIZE/HWDATA, either directly or through the bus decoder.
- Uses non-pipelined single transfers: one read, then one write, per word.
- Control comes from a local start/config interface, which the processor-side register block drives.

---
 rtl/ahb_dma_master.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ahb_dma_master.sv
// Single-channel AHB-Lite DMA master: copies word_count 32-bit words from src to dst
// using non-pipelined single transfers (one read then one write per word).
module ahb_dma_master #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [CNT_WIDTH-1:0] word_count,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [31:0]          HWDATA,
    input  logic [31:0]          HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR,
        S_WR_DATA,
        S_DONE,
        S_ERROR
    } state_e;

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    state_e               state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          buf_q, buf_d;
    logic [31:0]          haddr_q, haddr_d;
    logic [1:0]           htrans_q, htrans_d;
    logic                 hwrite_q, hwrite_d;
    logic [31:0]          hwdata_q, hwdata_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 error_q, error_d;
    logic                 accept;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        accept  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    src_d   = src_addr & ~32'h3;
                    dst_d   = dst_addr & ~32'h3;
                    cnt_d   = word_count;
                    state_d = (word_count == '0) ? S_DONE : S_RD_ADDR;
                end
            end
            S_RD_ADDR: if (HREADY) state_d = S_RD_DATA;
            S_RD_DATA: begin
                // HRESP is acted on in the first (HREADY=0) cycle of the error response.
                if (HRESP) begin
                    state_d = S_ERROR;
                end else if (HREADY) begin
                    buf_d   = HRDATA;
                    state_d = S_WR_ADDR;
                end
            end
            S_WR_ADDR: if (HREADY) state_d = S_WR_DATA;
            S_WR_DATA: begin
                if (HRESP) begin
                    state_d = S_ERROR;
                end else if (HREADY) begin
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    cnt_d   = cnt_q - CNT_WIDTH'(1);
                    state_d = (cnt_q == CNT_WIDTH'(1)) ? S_DONE : S_RD_ADDR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERROR: if (HREADY) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        haddr_d  = haddr_q;
        hwdata_d = hwdata_q;
        htrans_d = TRANS_IDLE;
        hwrite_d = (state_d == S_WR_ADDR) || (state_d == S_WR_DATA);
        busy_d   = (state_d != S_IDLE);
        done_d   = (state_d == S_DONE);
        error_d  = error_q;

        if (state_d == S_RD_ADDR) begin
            haddr_d  = src_d;
            htrans_d = TRANS_NONSEQ;
        end
        if (state_d == S_WR_ADDR) begin
            haddr_d  = dst_d;
            htrans_d = TRANS_NONSEQ;
        end
        if (state_d == S_WR_DATA) hwdata_d = buf_d;
        if (accept) error_d = 1'b0;
        if (state_d == S_ERROR) error_d = 1'b1;
    end

    always_ff @(posedge HCLK) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (HRESET) begin
            state_q  <= S_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            buf_q    <= '0;
            haddr_q  <= '0;
            htrans_q <= TRANS_IDLE;
            hwrite_q <= 1'b0;
            hwdata_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            buf_q    <= buf_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hwdata_q <= hwdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    assign HADDR  = haddr_q;
    assign HTRANS = htrans_q;
    assign HWRITE = hwrite_q;
    assign HSIZE  = 3'b010;
    assign HWDATA = hwdata_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule
